placement_verifier: RTL and testbench

Post-placement checker that runs after the random placer finishes. It reads the placer's position memories (X/Y), grid memory and edge ROMs through read-only ports, and checks that the placement is legal. It computes the total Manhattan wirelength, the 1-hop wirelength and the longest edge, then reports pass/fail with error flags. It sits directly downstream of the placer and is started by the placer's completion output.

---
 rtl/placement_pkg.sv | 22 ++
 rtl/pv_edge_cost.sv | 30 +++
 rtl/placement_verifier.sv | 248 ++++++++++++++++++++++++
 tb/tb_placement_verifier.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/placement_pkg.sv
// Shared definitions for the placement checker and the placer evaluation path.
package placement_pkg;

    // Marker for an empty grid cell or an unplaced coordinate.
    localparam logic signed [31:0] EMPTY = -32'sd1;

    // Bit positions inside err_flags.
    localparam int ERR_GRID  = 0;
    localparam int ERR_DUP   = 1;
    localparam int ERR_RANGE = 2;
    localparam int ERR_UNPL  = 3;

    // Checker sequencer states: grid scan, node scan, edge scan, finish.
    typedef enum logic [4:0] {
        IDLE,
        G_RD, G_WT, G_CHK, G_PRD, G_PWT, G_PCHK,
        P_RD, P_WT, P_CHK,
        E_RD, E_WT, E_PA, E_PAWT, E_PB, E_PBWT, E_ACC,
        FIN
    } pv_state_e;

endpackage

// File: rtl/pv_edge_cost.sv
// Combinational cost of one edge between (xa,ya) and (xb,yb):
// wirelength contribution, 1-hop contribution, Manhattan distance and overlap.
module pv_edge_cost (
    input  logic signed [31:0] xa_i,
    input  logic signed [31:0] ya_i,
    input  logic signed [31:0] xb_i,
    input  logic signed [31:0] yb_i,
    output logic signed [31:0] cost_o,
    output logic signed [31:0] hop_o,
    output logic signed [31:0] dist_o,
    output logic               overlap_o
);

    function automatic logic signed [31:0] abs_s(input logic signed [31:0] v);
        return (v < 0) ? -v : v;
    endfunction

    logic signed [31:0] dx, dy;

    // Distance terms; ceil(d/2) is (d+1)>>>1 for non-negative d.
    always_comb begin
        dx        = abs_s(xa_i - xb_i);
        dy        = abs_s(ya_i - yb_i);
        dist_o    = dx + dy;
        cost_o    = dist_o - 32'sd1;
        hop_o     = ((dx + 32'sd1) >>> 1) + ((dy + 32'sd1) >>> 1) - 32'sd1;
        overlap_o = (dist_o == 32'sd0);
    end

endmodule

// File: rtl/placement_verifier.sv
// Post-placement legality checker: scans the grid, then every node, then every
// edge, accumulating wirelength figures and sticky error flags.
module placement_verifier
    import placement_pkg::*;
#(
    parameter int N       = 6,
    parameter int N_NODES = 64,
    parameter int N_EDGE  = 32,
    parameter int GRID_AW = 12,
    parameter int POS_AW  = 7,
    parameter int EDGE_AW = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      grid_re,
    output logic [GRID_AW-1:0]        grid_addr,
    input  logic signed [31:0]        grid_dout,
    output logic                      pos_re,
    output logic [POS_AW-1:0]         pos_addr,
    input  logic signed [31:0]        pos_x,
    input  logic signed [31:0]        pos_y,
    output logic                      edge_re,
    output logic [EDGE_AW-1:0]        edge_addr,
    input  logic [31:0]               edge_a,
    input  logic [31:0]               edge_b,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [3:0]                err_flags,
    output logic [15:0]               err_count,
    output logic signed [31:0]        wirelength,
    output logic signed [31:0]        wl_1hop,
    output logic signed [31:0]        max_edge
);

    localparam int                  SEEN_W    = (N_NODES > 1) ? $clog2(N_NODES) : 1;
    localparam logic [GRID_AW-1:0]  LAST_CELL = GRID_AW'(N * N - 1);
    localparam logic [POS_AW-1:0]   LAST_NODE = POS_AW'(N_NODES - 1);
    localparam logic [EDGE_AW-1:0]  LAST_EDGE = EDGE_AW'(N_EDGE - 1);
    localparam logic signed [31:0]  N_S       = N;

    function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [2:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + {14'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    function automatic logic on_grid(input logic signed [31:0] c);
        return (c >= 0) && (c < N_S);
    endfunction

    pv_state_e state_q, state_d;

    logic [GRID_AW-1:0]  cell_q;
    logic [POS_AW-1:0]   node_q, v_q, a_q, b_q;
    logic                v_ok_q;
    logic [EDGE_AW-1:0]  edge_q;
    logic signed [31:0]  xa_q, ya_q;
    logic [N_NODES-1:0]  seen_q;
    logic [3:0]          flags_q;
    logic [15:0]         cnt_q;
    logic signed [31:0]  wl_q, hop_q, max_q;
    logic                res_q;

    logic signed [31:0]  ec_cost, ec_hop, ec_dist;
    logic                ec_overlap;

    logic                ev_grid, ev_dup, ev_range, ev_unpl, acc_en;
    logic [3:0]          ev_vec;
    logic [2:0]          ev_n;
    logic signed [31:0]  cell_s, g_pos_cell;
    logic                g_v_ok, p_empty, p_bad, e_unpl;
    logic [SEEN_W-1:0]   v_idx, n_idx;

    // Only the low address bits of an edge endpoint reach the position memory.
    logic unused_edge_bits;
    assign unused_edge_bits = ^{edge_a[31:POS_AW], edge_b[31:POS_AW]};

    // Endpoint A is latched one read earlier; endpoint B arrives on the bus in E_ACC.
    pv_edge_cost u_cost (
        .xa_i      (xa_q),
        .ya_i      (ya_q),
        .xb_i      (pos_x),
        .yb_i      (pos_y),
        .cost_o    (ec_cost),
        .hop_o     (ec_hop),
        .dist_o    (ec_dist),
        .overlap_o (ec_overlap)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state, read strobes, position address mux and status outputs.
    always_comb begin
        state_d  = state_q;
        grid_re  = 1'b0;
        pos_re   = 1'b0;
        edge_re  = 1'b0;
        pos_addr = '0;
        busy     = (state_q != IDLE) && (state_q != FIN);
        done     = (state_q == FIN);
        case (state_q)
            IDLE:   if (start) state_d = G_RD;
            G_RD:   begin grid_re = 1'b1; state_d = G_WT; end
            G_WT:   state_d = G_CHK;
            G_CHK: begin
                if (grid_dout != EMPTY)      state_d = G_PRD;
                else if (cell_q == LAST_CELL) state_d = P_RD;
                else                          state_d = G_RD;
            end
            G_PRD:  begin pos_re = 1'b1; pos_addr = v_q; state_d = G_PWT; end
            G_PWT:  begin pos_addr = v_q; state_d = G_PCHK; end
            G_PCHK: state_d = (cell_q == LAST_CELL) ? P_RD : G_RD;
            P_RD:   begin pos_re = 1'b1; pos_addr = node_q; state_d = P_WT; end
            P_WT:   begin pos_addr = node_q; state_d = P_CHK; end
            P_CHK:  state_d = (node_q == LAST_NODE) ? E_RD : P_RD;
            E_RD:   begin edge_re = 1'b1; state_d = E_WT; end
            E_WT:   state_d = E_PA;
            E_PA:   begin pos_re = 1'b1; pos_addr = edge_a[POS_AW-1:0]; state_d = E_PAWT; end
            E_PAWT: begin pos_addr = a_q; state_d = E_PB; end
            E_PB:   begin pos_re = 1'b1; pos_addr = b_q; state_d = E_PBWT; end
            E_PBWT: begin pos_addr = b_q; state_d = E_ACC; end
            E_ACC:  state_d = (edge_q == LAST_EDGE) ? FIN : E_RD;
            FIN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Error-event decode for the check states; several events may fire at once.
    always_comb begin
        ev_grid    = 1'b0;
        ev_dup     = 1'b0;
        ev_range   = 1'b0;
        ev_unpl    = 1'b0;
        acc_en     = 1'b0;
        cell_s     = $signed(32'(cell_q));
        g_pos_cell = pos_x * N_S + pos_y;
        g_v_ok     = (grid_dout >= 0) && (grid_dout < N_NODES);
        v_idx      = v_q[SEEN_W-1:0];
        n_idx      = node_q[SEEN_W-1:0];
        p_empty    = (pos_x == EMPTY) && (pos_y == EMPTY);
        p_bad      = !on_grid(pos_x) || !on_grid(pos_y);
        e_unpl     = (xa_q == EMPTY) || (ya_q == EMPTY) || (pos_x == EMPTY) || (pos_y == EMPTY);
        case (state_q)
            G_PCHK: begin
                ev_grid = (g_pos_cell != cell_s);
                ev_dup  = v_ok_q && seen_q[v_idx];
            end
            P_CHK: begin
                ev_range = !p_empty && p_bad;
                ev_grid  = !p_empty && !p_bad && !seen_q[n_idx];
            end
            E_ACC: begin
                ev_unpl = e_unpl;
                ev_dup  = !e_unpl && ec_overlap;
                acc_en  = !e_unpl;
            end
            default: ;
        endcase
        ev_vec            = '0;
        ev_vec[ERR_GRID]  = ev_grid;
        ev_vec[ERR_DUP]   = ev_dup;
        ev_vec[ERR_RANGE] = ev_range;
        ev_vec[ERR_UNPL]  = ev_unpl;
        ev_n = 3'(ev_grid) + 3'(ev_dup) + 3'(ev_range) + 3'(ev_unpl);
    end

    // Scan counters, operand latches, seen bitmap, flags and accumulators.
    always_ff @(posedge clk) begin
        if (reset) begin
            cell_q  <= '0;
            node_q  <= '0;
            edge_q  <= '0;
            v_q     <= '0;
            v_ok_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            xa_q    <= '0;
            ya_q    <= '0;
            seen_q  <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
            wl_q    <= '0;
            hop_q   <= '0;
            max_q   <= '0;
            res_q   <= 1'b0;
        end else if (state_q == IDLE) begin
            if (start) begin
                cell_q  <= '0;
                node_q  <= '0;
                edge_q  <= '0;
                seen_q  <= '0;
                flags_q <= '0;
                cnt_q   <= '0;
                wl_q    <= '0;
                hop_q   <= '0;
                max_q   <= '0;
                res_q   <= 1'b0;
            end
        end else begin
            flags_q <= flags_q | ev_vec;
            cnt_q   <= sat_add(cnt_q, ev_n);
            if (acc_en) begin
                wl_q  <= wl_q + ec_cost;
                hop_q <= hop_q + ec_hop;
                if (ec_dist > max_q) max_q <= ec_dist;
            end
            case (state_q)
                G_CHK: begin
                    v_q    <= grid_dout[POS_AW-1:0];
                    v_ok_q <= g_v_ok;
                    if (grid_dout == EMPTY) cell_q <= cell_q + GRID_AW'(1);
                end
                G_PCHK: begin
                    if (v_ok_q) seen_q[v_idx] <= 1'b1;
                    cell_q <= cell_q + GRID_AW'(1);
                end
                P_CHK:  node_q <= node_q + POS_AW'(1);
                E_PA: begin
                    a_q <= edge_a[POS_AW-1:0];
                    b_q <= edge_b[POS_AW-1:0];
                end
                E_PB: begin
                    xa_q <= pos_x;
                    ya_q <= pos_y;
                end
                E_ACC:  edge_q <= edge_q + EDGE_AW'(1);
                default: ;
            endcase
            if (state_d == FIN) res_q <= 1'b1;
        end
    end

    assign grid_addr  = cell_q;
    assign edge_addr  = edge_q;
    assign pass       = res_q && (flags_q == 4'd0);
    assign err_flags  = flags_q;
    assign err_count  = cnt_q;
    assign wirelength = wl_q;
    assign wl_1hop    = hop_q;
    assign max_edge   = max_q;

endmodule

// File: tb/tb_placement_verifier.sv
// Bench for placement_verifier: directed placements, a loop-based reference
// model of the checking rules, and a per-cycle compare process.
module tb_placement_verifier;

    localparam int N = 6, NN = 8, NE = 2, GAW = 12, PAW = 7, EAW = 7;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic grid_re, pos_re, edge_re;
    logic [GAW-1:0] grid_addr;
    logic [PAW-1:0] pos_addr;
    logic [EAW-1:0] edge_addr;
    logic signed [31:0] grid_dout = 0, pos_x = 0, pos_y = 0;
    logic [31:0] edge_a = 0, edge_b = 0;
    logic busy, done, pass;
    logic [3:0] err_flags;
    logic [15:0] err_count;
    logic signed [31:0] wirelength, wl_1hop, max_edge;

    placement_verifier #(.N(N), .N_NODES(NN), .N_EDGE(NE), .GRID_AW(GAW), .POS_AW(PAW), .EDGE_AW(EAW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .grid_re(grid_re), .grid_addr(grid_addr), .grid_dout(grid_dout),
        .pos_re(pos_re), .pos_addr(pos_addr), .pos_x(pos_x), .pos_y(pos_y),
        .edge_re(edge_re), .edge_addr(edge_addr), .edge_a(edge_a), .edge_b(edge_b),
        .busy(busy), .done(done), .pass(pass), .err_flags(err_flags), .err_count(err_count),
        .wirelength(wirelength), .wl_1hop(wl_1hop), .max_edge(max_edge)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents
    int grid_m [N*N];
    int px_m [NN], py_m [NN];
    int ea_m [NE], eb_m [NE];

    function automatic int rd_grid(input logic [GAW-1:0] a);
        if (int'(a) < N*N) return grid_m[int'(a)];
        return -1;
    endfunction
    function automatic int rd_px(input logic [PAW-1:0] a);
        if (int'(a) < NN) return px_m[int'(a)];
        return -1;
    endfunction
    function automatic int rd_py(input logic [PAW-1:0] a);
        if (int'(a) < NN) return py_m[int'(a)];
        return -1;
    endfunction
    function automatic int rd_ea(input logic [EAW-1:0] a);
        if (int'(a) < NE) return ea_m[int'(a)];
        return 0;
    endfunction
    function automatic int rd_eb(input logic [EAW-1:0] a);
        if (int'(a) < NE) return eb_m[int'(a)];
        return 0;
    endfunction

    // Synchronous-read memories: data appears on the second edge after re.
    int g_s1 = 0, px_s1 = 0, py_s1 = 0, ea_s1 = 0, eb_s1 = 0;
    always @(posedge clk) begin
        if (grid_re) g_s1 <= rd_grid(grid_addr);
        if (pos_re) begin
            px_s1 <= rd_px(pos_addr);
            py_s1 <= rd_py(pos_addr);
        end
        if (edge_re) begin
            ea_s1 <= rd_ea(edge_addr);
            eb_s1 <= rd_eb(edge_addr);
        end
        grid_dout <= g_s1;
        pos_x     <= px_s1;
        pos_y     <= py_s1;
        edge_a    <= ea_s1;
        edge_b    <= eb_s1;
    end

    int n_checks = 0, n_fail = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, $signed(act), act, $signed(exp_v), exp_v, cyc);
        end
    endfunction

    // Reference model results
    logic [3:0] exp_flags = '0;
    int exp_cnt = 0, exp_wl = 0, exp_hop = 0, exp_max = 0, exp_lat = 1000000;
    bit exp_pass = 0;

    task automatic model_run();
        bit seen [NN];
        int lat, v, a, b, dx, dy;
        exp_flags = '0; exp_cnt = 0; exp_wl = 0; exp_hop = 0; exp_max = 0;
        for (int i = 0; i < NN; i++) seen[i] = 0;
        lat = 1;
        for (int c = 0; c < N*N; c++) begin
            lat += 3;
            if (grid_m[c] != -1) begin
                lat += 3;
                v = grid_m[c];
                if (px_m[v]*N + py_m[v] != c) begin exp_flags[0] = 1; exp_cnt++; end
                if (seen[v]) begin exp_flags[1] = 1; exp_cnt++; end
                seen[v] = 1;
            end
        end
        for (int n = 0; n < NN; n++) begin
            lat += 3;
            if (px_m[n] == -1 && py_m[n] == -1) continue;
            if (px_m[n] < 0 || px_m[n] >= N || py_m[n] < 0 || py_m[n] >= N) begin
                exp_flags[2] = 1; exp_cnt++;
            end else if (!seen[n]) begin
                exp_flags[0] = 1; exp_cnt++;
            end
        end
        for (int e = 0; e < NE; e++) begin
            lat += 7;
            a = ea_m[e]; b = eb_m[e];
            if (px_m[a] == -1 || py_m[a] == -1 || px_m[b] == -1 || py_m[b] == -1) begin
                exp_flags[3] = 1; exp_cnt++;
            end else begin
                dx = px_m[a] - px_m[b]; if (dx < 0) dx = -dx;
                dy = py_m[a] - py_m[b]; if (dy < 0) dy = -dy;
                exp_wl  += dx + dy - 1;
                exp_hop += (dx + 1) / 2 + (dy + 1) / 2 - 1;
                if (dx + dy > exp_max) exp_max = dx + dy;
                if (dx + dy == 0) begin exp_flags[1] = 1; exp_cnt++; end
            end
        end
        exp_lat  = lat;
        exp_pass = (exp_flags == 4'd0);
    endtask

    // 0: outputs must be all-zero (after reset); 1: run in progress / results held
    int mon_mode = 0;
    int start_cyc = 0;

    initial begin : compare
        int k;
        bit eb;
        logic pg, pp, pe;
        pg = 0; pp = 0; pe = 0;
        forever begin
            @(negedge clk);
            if (mon_mode == 0) begin
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_pass", pass, 0);
                chk("rst_flags", err_flags, 0);
                chk("rst_count", err_count, 0);
                chk("rst_wl", wirelength, 0);
                chk("rst_hop", wl_1hop, 0);
                chk("rst_max", max_edge, 0);
                chk("rst_strobes", {grid_re, pos_re, edge_re}, 0);
                chk("rst_addr", {grid_addr, pos_addr, edge_addr}, 0);
            end else begin
                k  = cyc - start_cyc;
                eb = (k >= 1) && (k < exp_lat);
                chk("busy", busy, eb);
                chk("done", done, (k == exp_lat));
                if (!eb) chk("strobe_when_idle", {grid_re, pos_re, edge_re}, 0);
                if (k >= exp_lat) begin
                    chk("pass", pass, exp_pass);
                    chk("err_flags", err_flags, exp_flags);
                    chk("err_count", err_count, exp_cnt);
                    chk("wirelength", wirelength, exp_wl);
                    chk("wl_1hop", wl_1hop, exp_hop);
                    chk("max_edge", max_edge, exp_max);
                end
            end
            chk("grid_re_pulse", grid_re & pg, 0);
            chk("pos_re_pulse", pos_re & pp, 0);
            chk("edge_re_pulse", edge_re & pe, 0);
            pg = grid_re; pp = pos_re; pe = edge_re;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        @(posedge clk); #1;
        model_run();
        start = 1; start_cyc = cyc; mon_mode = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_done(output int k);
        int n;
        n = 0;
        k = -1;
        while (1) begin
            @(negedge clk);
            if (done === 1'b1) begin k = cyc - start_cyc; break; end
            n++;
            if (n > 3000) begin chk("done_timeout", 0, 1); break; end
        end
    endtask

    task automatic finish_check(input string nm, input int lat, input logic [3:0] fl, input bit ps,
                                input int cnt, input int wl, input int hop, input int mx);
        int k;
        chk({nm, "_model_lat"}, exp_lat, lat);
        chk({nm, "_model_wl"}, exp_wl, wl);
        chk({nm, "_model_flags"}, exp_flags, fl);
        wait_done(k);
        chk({nm, "_latency"}, k, lat);
        chk({nm, "_flags"}, err_flags, fl);
        chk({nm, "_pass"}, pass, ps);
        chk({nm, "_count"}, err_count, cnt);
        chk({nm, "_wl"}, wirelength, wl);
        chk({nm, "_hop"}, wl_1hop, hop);
        chk({nm, "_max"}, max_edge, mx);
        idle(6);
    endtask

    task automatic setup_base();
        for (int i = 0; i < N*N; i++) grid_m[i] = -1;
        for (int i = 0; i < NN; i++) begin px_m[i] = -1; py_m[i] = -1; end
        px_m[0] = 0; py_m[0] = 0; grid_m[0]  = 0;
        px_m[1] = 0; py_m[1] = 1; grid_m[1]  = 1;
        px_m[2] = 2; py_m[2] = 3; grid_m[15] = 2;
        ea_m[0] = 0; eb_m[0] = 1;
        ea_m[1] = 1; eb_m[1] = 2;
    endtask

    initial begin : stimulus
        setup_base();
        idle(3);
        reset = 0;
        idle(3);

        // Legal placement
        setup_base();
        do_start();
        finish_check("legal", 156, 4'b0000, 1, 0, 3, 1, 4);

        // grid[7]=3 but node 3 sits at (2,2)
        setup_base();
        grid_m[7] = 3; px_m[3] = 2; py_m[3] = 2;
        do_start();
        finish_check("mismatch", 159, 4'b0001, 0, 1, 3, 1, 4);

        // node 4 off the grid, no grid entry
        setup_base();
        px_m[4] = 6; py_m[4] = 0;
        do_start();
        finish_check("range", 156, 4'b0100, 0, 1, 3, 1, 4);

        // edge to an unplaced node
        setup_base();
        ea_m[0] = 0; eb_m[0] = 5;
        do_start();
        finish_check("unplaced", 156, 4'b1000, 0, 1, 3, 1, 4);

        // node 3 overlaps node 0 and is absent from the grid; edge (0,3) has zero length
        setup_base();
        px_m[3] = 0; py_m[3] = 0;
        ea_m[0] = 0; eb_m[0] = 3;
        do_start();
        finish_check("overlap", 156, 4'b0011, 0, 2, 2, 0, 4);

        // node 0 listed twice in the grid: mismatch and duplicate in the same check
        setup_base();
        grid_m[20] = 0;
        do_start();
        finish_check("griddup", 159, 4'b0011, 0, 2, 3, 1, 4);

        // reset while waiting for endpoint A of the first edge, then rerun
        setup_base();
        do_start();
        while (cyc - start_cyc != 145) begin
            @(posedge clk); #1;
        end
        reset = 1;
        @(posedge clk); #1;
        mon_mode = 0;
        reset = 0;
        idle(5);
        do_start();
        finish_check("rerun", 156, 4'b0000, 1, 0, 3, 1, 4);

        // second start while busy is ignored
        setup_base();
        do_start();
        while (cyc - start_cyc != 50) begin
            @(posedge clk); #1;
        end
        start = 1;
        @(posedge clk); #1;
        start = 0;
        finish_check("restart", 156, 4'b0000, 1, 0, 3, 1, 4);
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
